hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

- Read-after-write hazard detector for the 5-phase single-thread pipeline.
- Tracks the destination register of every instruction in flight in phases 3–5.
- Compares them against the sources of the instruction in register fetch (phase 2).
- Raises `reg_fetch_freeze_out`, the signal the control unit consumes as its register-fetch freeze request. It also squashes tracked entries on a taken branch.

## Interface
Parameters:
- `STAGES`, 3: number of tracked in-flight stages (EX, MEM, WB).
- `CNT_W`, 16: width of the stall-cycle counter.

Ports:
- `clock` in 1: single clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `enable_in` in 1: 1 = pipeline advancing; 0 = tag pipeline holds, freeze output forced 0.
- `id_valid_in` in 1: phase-2 slot holds a real instruction.
- `id_rs_in` in 5: first source register.
- `id_rt_in` in 5: second source register.
- `id_read_rs_in` in 1: rs is actually read.
- `id_read_rt_in` in 1: rt is actually read.
- `id_read_special_in` in 1: instruction reads HI/LO.
- `id_write_in` in 1: instruction writes a general register.
- `id_write_reg_in` in 5: destination register.
- `id_write_special_in` in 1: instruction writes HI/LO.
- `branch_taken_in` in 1: taken-branch flush request.
- `reg_fetch_freeze_out` out 1: RAW stall request to the control unit.
- `pending_mask_out` out 32: bit n = register n has a pending write.
- `stall_count_out` out CNT_W: saturating count of stall cycles.

## Operation
Each stage entry holds {valid, reg[4:0], special}.

Hazard match:
- Match on a valid entry when either condition holds:
  - A read source equals `reg` and `reg != 0`.
  - `id_read_special_in` is set and `special` is 1.
- Register 0 never matches and is never set in `pending_mask_out`.

`reg_fetch_freeze_out` is asserted when all of the following hold:
- `enable_in` = 1
- `id_valid_in` = 1
- `branch_taken_in` = 0
- some stage matches

Advance (posedge, `enable_in` = 1):
- WB entry retires.
- MEM moves to WB; EX moves to MEM.
- EX loads depending on conditions:
  - No stall: EX loads the ID instruction, valid = `id_valid_in` & (`id_write_in` | `id_write_special_in`).
  - Stall: EX loads a bubble (valid = 0); the ID instruction is re-presented by the held upstream.

Flush (posedge with `branch_taken_in` = 1):
- EX loads a bubble, squashing the ID instruction.
- The current EX entry is invalidated before moving to MEM.
- The current MEM entry is unaffected.

Other state rules:
- `enable_in` = 0: all entries hold; counter holds.
- `stall_count_out` increments on every posedge where `reg_fetch_freeze_out` = 1 and saturates at all-ones.
- `pending_mask_out` is the OR of one-hot decodes of all valid non-special entries.

## Timing
- Reset values: all entries invalid, `reg_fetch_freeze_out` = 0, `pending_mask_out` = 0, `stall_count_out` = 0.
- `reg_fetch_freeze_out` is combinational from ID inputs and stage registers, valid in the same cycle.
- Producer issued in cycle 0, dependent instruction in cycle 1:
  - Without `HAZARD_WB_BYPASS_EN`: stalls cycles 1–3, proceeds in cycle 4.
  - With `HAZARD_WB_BYPASS_EN`: stalls cycles 1–2.
- Dependent instruction two behind the producer: 2 stall cycles (1 with the macro).
- Simultaneous flush and match: flush wins, freeze = 0, ID squashed.
- Reset asserted mid-stall: freeze drops immediately (async) and entries clear.

## Configuration
`HAZARD_WB_BYPASS_EN`:
- Defined: the WB-stage entry is excluded from matching, because the register file writes before it reads in the same cycle.
- Undefined: all `STAGES` entries are matched.

## Structure
- Package `hazard_pkg`:
  - typedef `tag_entry_t` {valid, reg, special}
  - constant `REG_ZERO`
  - default `STAGES`
- Sub-module `hazard_tag_match`: compares one `tag_entry_t` against the ID sources and produces a match bit. It is instantiated once per stage in a generate loop.

## Test plan
- `addi` r5 issued, next cycle `add` reading r5 → freeze high exactly 3 cycles (2 with the macro); `stall_count_out` = 3.
- Producer writes r0, consumer reads r0 → freeze never asserted; `pending_mask_out` stays 0.
- `mtlo` followed by `mflo` → freeze via the special flag; `pending_mask_out` = 0 throughout.
- Producer r7 in EX, consumer reading r7, `branch_taken_in` pulsed → freeze 0 that cycle; next cycle the EX and MEM entries are invalid and no stall for r7.
- `enable_in` low for 4 cycles mid-stall → entries hold, freeze 0; stall resumes for the remaining cycles after re-enable.
- `reset` asserted between clock edges during a stall → outputs zero immediately; counter preset near max saturates at all-ones.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the RAW hazard scoreboard.
package hazard_pkg;

  localparam int         DEFAULT_STAGES = 3;
  localparam logic [4:0] REG_ZERO       = 5'd0;

  typedef struct packed {
    logic       valid;
    logic [4:0] reg_idx;
    logic       special;
  } tag_entry_t;

endpackage

// File: rtl/hazard_tag_match.sv
// Compares one in-flight destination tag against the register-fetch sources.
module hazard_tag_match
  import hazard_pkg::*;
(
  input  tag_entry_t entry,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       read_rs,
  input  logic       read_rt,
  input  logic       read_special,
  output logic       match
);

  // r0 is hardwired, so a tag of zero can never create a dependency
  always_comb begin
    match = 1'b0;
    if (entry.valid) begin
      match = (read_rs && (id_rs == entry.reg_idx) && (id_rs != REG_ZERO)) ||
              (read_rt && (id_rt == entry.reg_idx) && (id_rt != REG_ZERO)) ||
              (read_special && entry.special);
    end else begin
      match = 1'b0;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// RAW hazard scoreboard for the 5-phase pipeline (EX/MEM/WB tags vs. ID sources).
// Optional macro HAZARD_WB_BYPASS_EN drops the WB entry from matching.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int STAGES = DEFAULT_STAGES,
  parameter int CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable_in,
  input  logic             id_valid_in,
  input  logic [4:0]       id_rs_in,
  input  logic [4:0]       id_rt_in,
  input  logic             id_read_rs_in,
  input  logic             id_read_rt_in,
  input  logic             id_read_special_in,
  input  logic             id_write_in,
  input  logic [4:0]       id_write_reg_in,
  input  logic             id_write_special_in,
  input  logic             branch_taken_in,
  output logic             reg_fetch_freeze_out,
  output logic [31:0]      pending_mask_out,
  output logic [CNT_W-1:0] stall_count_out
);

  tag_entry_t        stage_r [STAGES];
  tag_entry_t        ex_next_s;
  logic [STAGES-1:0] match_s;
  logic [STAGES-1:0] match_used_s;
  logic              freeze_s;
  logic [CNT_W-1:0]  stall_count_r;

  for (genvar g = 0; g < STAGES; g++) begin : gen_match
    hazard_tag_match u_match (
      .entry        (stage_r[g]),
      .id_rs        (id_rs_in),
      .id_rt        (id_rt_in),
      .read_rs      (id_read_rs_in),
      .read_rt      (id_read_rt_in),
      .read_special (id_read_special_in),
      .match        (match_s[g])
    );
  end

  // Select which stages may raise a stall
  always_comb begin
    match_used_s = match_s;
`ifdef HAZARD_WB_BYPASS_EN
    match_used_s[STAGES-1] = 1'b0;
`endif
    freeze_s = enable_in & id_valid_in & ~branch_taken_in & (|match_used_s);
  end

  // Tag presented to EX: a bubble on stall or flush
  always_comb begin
    ex_next_s = '0;
    if (!freeze_s && !branch_taken_in) begin
      ex_next_s.valid   = id_valid_in & (id_write_in | id_write_special_in);
      ex_next_s.reg_idx = id_write_in ? id_write_reg_in : REG_ZERO;
      ex_next_s.special = id_write_special_in;
    end else begin
      ex_next_s = '0;
    end
  end

  // Tag pipeline shift; a taken branch also kills the entry leaving EX
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stage_r[i] <= '0;
    end else if (enable_in) begin
      stage_r[0] <= ex_next_s;
      for (int i = 1; i < STAGES; i++) begin
        stage_r[i] <= (i == 1 && branch_taken_in) ? '0 : stage_r[i-1];
      end
    end
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count_r <= '0;
    end else if (freeze_s && (stall_count_r != {CNT_W{1'b1}})) begin
      stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Pending general-register writes, HI/LO writers excluded
  always_comb begin
    pending_mask_out = 32'd0;
    for (int i = 0; i < STAGES; i++) begin
      if (stage_r[i].valid && !stage_r[i].special && (stage_r[i].reg_idx != REG_ZERO)) begin
        pending_mask_out[stage_r[i].reg_idx] = 1'b1;
      end else begin
        pending_mask_out = pending_mask_out;
      end
    end
  end

  assign reg_fetch_freeze_out = freeze_s;
  assign stall_count_out      = stall_count_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: table vectors, directed corner cases, random vs. in-flight model.
module tb_hazard_scoreboard;

`ifdef HAZARD_WB_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif
  localparam int NST = 3 - BYP;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, en, valid, rdrs, rdrt, rdsp, wr, wsp, br;
  logic [4:0]  rs, rt, wreg;
  logic        freeze, freeze2;
  logic [31:0] mask, mask2;
  logic [15:0] cnt;
  logic [1:0]  cnt2;

  hazard_scoreboard #(.STAGES(3), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .enable_in(en), .id_valid_in(valid),
    .id_rs_in(rs), .id_rt_in(rt), .id_read_rs_in(rdrs), .id_read_rt_in(rdrt),
    .id_read_special_in(rdsp), .id_write_in(wr), .id_write_reg_in(wreg),
    .id_write_special_in(wsp), .branch_taken_in(br),
    .reg_fetch_freeze_out(freeze), .pending_mask_out(mask), .stall_count_out(cnt)
  );

  hazard_scoreboard #(.STAGES(3), .CNT_W(2)) dut_sat (
    .clock(clock), .reset(reset), .enable_in(en), .id_valid_in(valid),
    .id_rs_in(rs), .id_rt_in(rt), .id_read_rs_in(rdrs), .id_read_rt_in(rdrt),
    .id_read_special_in(rdsp), .id_write_in(wr), .id_write_reg_in(wreg),
    .id_write_special_in(wsp), .branch_taken_in(br),
    .reg_fetch_freeze_out(freeze2), .pending_mask_out(mask2), .stall_count_out(cnt2)
  );

  // Reference: a list of writes still in flight, each with cycles left before retiring
  typedef struct { logic [4:0] r; logic sp; int rem; } flight_t;
  flight_t q[$];
  int      m_cnt;
  int      n_vec = 0;
  int      n_err = 0;
  logic    last_f;

  typedef struct {
    logic v; logic [4:0] rs; logic rdrs; logic rdsp; logic wr; logic [4:0] wreg;
    logic wsp; logic br; logic ef; logic [31:0] em;
  } vec_t;
  vec_t tbl[14];

  function automatic vec_t mk(logic v, logic [4:0] s, logic rr, logic rsp, logic w,
                              logic [4:0] wd, logic ws, logic b, logic ef, logic [31:0] em);
    vec_t t;
    t.v = v; t.rs = s; t.rdrs = rr; t.rdsp = rsp; t.wr = w; t.wreg = wd;
    t.wsp = ws; t.br = b; t.ef = ef; t.em = em;
    return t;
  endfunction

  function automatic logic m_freeze();
    if (!en || !valid || br) return 1'b0;
    foreach (q[i]) begin
      if (q[i].rem > BYP) begin
        if (rdrs && rs != 5'd0 && rs == q[i].r) return 1'b1;
        if (rdrt && rt != 5'd0 && rt == q[i].r) return 1'b1;
        if (rdsp && q[i].sp) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] m = 32'd0;
    foreach (q[i]) if (!q[i].sp && q[i].r != 5'd0) m = m | (32'd1 << q[i].r);
    return m;
  endfunction

  task automatic m_edge(input logic f);
    flight_t nq[$];
    flight_t e;
    if (!en) return;
    if (f) m_cnt = m_cnt + 1;
    foreach (q[i]) begin
      if (!(br && q[i].rem == 3) && q[i].rem > 1) begin
        e = q[i]; e.rem = e.rem - 1; nq.push_back(e);
      end
    end
    if (!f && !br && valid && (wr || wsp)) begin
      e.r = wr ? wreg : 5'd0; e.sp = wsp; e.rem = 3; nq.push_back(e);
    end
    q = nq;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    en = 1'b1; valid = 1'b0; rs = 5'd0; rt = 5'd0; rdrs = 1'b0; rdrt = 1'b0;
    rdsp = 1'b0; wr = 1'b0; wreg = 5'd0; wsp = 1'b0; br = 1'b0;
  endtask

  task automatic issue_write(input logic [4:0] d);
    idle(); valid = 1'b1; wr = 1'b1; wreg = d;
  endtask

  task automatic issue_read(input logic [4:0] s, input logic [4:0] d);
    idle(); valid = 1'b1; rs = s; rdrs = 1'b1; rdrt = 1'b1; wr = 1'b1; wreg = d;
  endtask

  // One cycle: inputs are already stable; check mid-cycle, then advance model on the edge
  task automatic step(input bit use_tbl, input logic ef, input logic [31:0] em);
    logic f;
    #4;
    f = m_freeze();
    last_f = freeze;
    chk("freeze", freeze, f);
    chk("pending_mask", mask, m_mask());
    chk("stall_count", cnt, m_cnt);
    chk("stall_count_sat", cnt2, (m_cnt > 3) ? 3 : m_cnt);
    if (use_tbl) begin
      chk("tbl_freeze", freeze, ef);
      chk("tbl_mask", mask, em);
    end
    @(posedge clock);
    m_edge(f);
    #1;
  endtask

  task automatic count_stalls(output int st);
    st = 0;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, 32'd0);
      if (last_f) st++;
      else break;
    end
  endtask

  initial begin
    int st;
    idle();
    reset = 1'b1;
    m_cnt = 0;
    #1;
    chk("reset_freeze", freeze, 1'b0);
    chk("reset_mask", mask, 32'd0);
    chk("reset_count", cnt, 16'd0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;

    // addi r5 then dependent add
    issue_write(5'd5); step(1'b0, 1'b0, 32'd0);
    issue_read(5'd5, 5'd10); count_stalls(st);
    chk("r5_stall_cycles", st, NST);
    chk("r5_stall_count", cnt, NST);
    idle(); repeat (3) step(1'b0, 1'b0, 32'd0);

    // same again: the 2-bit counter must stick at all-ones
    issue_write(5'd5); step(1'b0, 1'b0, 32'd0);
    issue_read(5'd5, 5'd10); count_stalls(st);
    chk("sat_count_wide", cnt, 2 * NST);
    chk("sat_count_narrow", cnt2, 2'b11);
    idle(); repeat (3) step(1'b0, 1'b0, 32'd0);

    // r0 producer/consumer, mtlo/mflo, flush with r7
    tbl[0]  = mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 32'd0);
    tbl[1]  = mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 32'd0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0);
    tbl[3]  = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 32'd0);
    tbl[4]  = mk(1, 0, 0, 1, 1, 8, 0, 0, 1, 32'd0);
    tbl[5]  = mk(1, 0, 0, 1, 1, 8, 0, 0, 1, 32'd0);
    tbl[6]  = mk(1, 0, 0, 1, 1, 8, 0, 0, NST == 3, 32'd0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, (NST == 2) ? 32'h100 : 32'd0);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, (NST == 2) ? 32'h100 : 32'd0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, (NST == 2) ? 32'h100 : 32'd0);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0);
    tbl[11] = mk(1, 0, 0, 0, 1, 7, 0, 0, 0, 32'd0);
    tbl[12] = mk(1, 7, 1, 0, 1, 9, 0, 1, 0, 32'h80);
    tbl[13] = mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 32'd0);
    for (int i = 0; i < 14; i++) begin
      idle();
      valid = tbl[i].v; rs = tbl[i].rs; rdrs = tbl[i].rdrs; rdsp = tbl[i].rdsp;
      wr = tbl[i].wr; wreg = tbl[i].wreg; wsp = tbl[i].wsp; br = tbl[i].br;
      step(1'b1, tbl[i].ef, tbl[i].em);
    end
    idle(); repeat (3) step(1'b0, 1'b0, 32'd0);

    // enable low for 4 cycles in the middle of a stall
    issue_write(5'd5); step(1'b0, 1'b0, 32'd0);
    issue_read(5'd5, 5'd11); step(1'b0, 1'b0, 32'd0);
    chk("en_first_stall", last_f, 1'b1);
    en = 1'b0;
    repeat (4) begin
      step(1'b0, 1'b0, 32'd0);
      chk("en_low_freeze", last_f, 1'b0);
      chk("en_low_mask_hold", mask, 32'h20);
    end
    en = 1'b1; count_stalls(st);
    chk("en_remaining_stalls", st, NST - 1);
    idle(); repeat (3) step(1'b0, 1'b0, 32'd0);

    // async reset between edges during a stall
    issue_write(5'd6); step(1'b0, 1'b0, 32'd0);
    issue_read(5'd6, 5'd12); step(1'b0, 1'b0, 32'd0);
    #3 reset = 1'b1;
    #1;
    chk("rst_mid_freeze", freeze, 1'b0);
    chk("rst_mid_mask", mask, 32'd0);
    chk("rst_mid_count", cnt, 16'd0);
    chk("rst_mid_count_sat", cnt2, 2'd0);
    q.delete(); m_cnt = 0;
    @(posedge clock); #1;
    reset = 1'b0;
    step(1'b0, 1'b0, 32'd0);
    idle(); repeat (3) step(1'b0, 1'b0, 32'd0);

    // random traffic against the in-flight model
    for (int n = 0; n < 400; n++) begin
      en    = ($urandom_range(0, 9) != 0);
      valid = ($urandom_range(0, 4) != 0);
      rs    = 5'($urandom_range(0, 7));
      rt    = 5'($urandom_range(0, 7));
      rdrs  = 1'($urandom_range(0, 1));
      rdrt  = 1'($urandom_range(0, 1));
      rdsp  = ($urandom_range(0, 5) == 0);
      wr    = 1'($urandom_range(0, 1));
      wreg  = 5'($urandom_range(0, 7));
      wsp   = ($urandom_range(0, 5) == 0);
      br    = ($urandom_range(0, 11) == 0);
      step(1'b0, 1'b0, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
